// File: rtl/seq_divider_8by4.sv
// Sequential restoring divider, 8-bit dividend by 4-bit divisor.
// One quotient bit per clock; start/busy/done handshake; results held until the next completion.
module seq_divider_8by4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [4:0]  pr_q, pr_d;
  logic [3:0]  dvsr_q, dvsr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  quot_q, quot_d;
  logic [3:0]  rem_q, rem_d;
  logic        dbz_q, dbz_d;

  logic [4:0]  pr_shl;
  logic [4:0]  pr_new;
  logic        q_bit;
  logic [7:0]  shift_new;

  // Restoring step: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    pr_shl    = {pr_q[3:0], shift_q[7]};
    q_bit     = 1'b0;
    pr_new    = pr_shl;
    if (pr_shl >= {1'b0, dvsr_q}) begin
      pr_new = pr_shl - {1'b0, dvsr_q};
      q_bit  = 1'b1;
    end
    shift_new = {shift_q[6:0], q_bit};
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    pr_d    = pr_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          shift_d = dividend;
          dvsr_d  = divisor;
          pr_d    = 5'd0;
          cnt_d   = 3'd0;
          if (divisor == 4'd0) begin
            state_d = DONE;
            quot_d  = 8'hFF;
            rem_d   = 4'h0;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        shift_d = shift_new;
        pr_d    = pr_new;
        cnt_d   = cnt_q + 3'd1;
        // Eighth iteration: counter wraps and results publish.
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          quot_d  = shift_new;
          rem_d   = pr_new[3:0];
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= 8'd0;
      pr_q    <= 5'd0;
      dvsr_q  <= 4'd0;
      cnt_q   <= 3'd0;
      quot_q  <= 8'd0;
      rem_q   <= 4'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      pr_q    <= pr_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider_8by4.sv
// Bench for seq_divider_8by4: cycle-level behavioural model checked every cycle,
// plus directed vectors with hand-computed results and an exhaustive sweep.
module tb_seq_divider_8by4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider_8by4 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Behavioural model: phase (0 idle, 1 computing, 2 done), cycles left, arithmetic results.
  int         m_st = 0;
  int         m_cnt = 0;
  int         m_a = 0;
  int         m_b = 0;
  logic [7:0] m_q = 8'd0;
  logic [3:0] m_r = 4'd0;
  logic       m_z = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= 0; m_cnt <= 0; m_q <= 8'd0; m_r <= 4'd0; m_z <= 1'b0;
    end else if (m_st == 1) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_st <= 2;
        m_q  <= 8'(m_a / m_b);
        m_r  <= 4'(m_a % m_b);
        m_z  <= 1'b0;
      end
    end else if (start) begin
      m_a <= int'(dividend);
      m_b <= int'(divisor);
      if (divisor == 4'd0) begin
        m_st <= 2; m_q <= 8'hFF; m_r <= 4'd0; m_z <= 1'b1;
      end else begin
        m_st <= 1; m_cnt <= 8;
      end
    end else begin
      m_st <= 0;
    end
  end

  always @(negedge clk) begin
    chk("model_busy", 32'(busy), 32'(m_st == 1));
    chk("model_done", 32'(done), 32'(m_st == 2));
    chk("model_quotient", 32'(quotient), 32'(m_q));
    chk("model_remainder", 32'(remainder), 32'(m_r));
    chk("model_dbz", 32'(div_by_zero), 32'(m_z));
  end

  // Called at 1 time unit after a rising edge; returns at the same phase of the done cycle.
  task automatic run(input logic [7:0] a, input logic [3:0] b,
                     input int eq, input int er, input int ez);
    int k;
    int nb;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; nb = 0;
    while (!done && k < 20) begin
      if (busy) nb++;
      @(posedge clk); #1;
      k++;
    end
    if (k >= 20) begin
      checks++; errors++;
      $display("FAIL timeout %0d/%0d no done", a, b);
    end
    chk("latency", 32'(k), (b == 4'd0) ? 32'd0 : 32'd8);
    chk("busy_cycles", 32'(nb), (b == 4'd0) ? 32'd0 : 32'd8);
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("div_by_zero", 32'(div_by_zero), 32'(ez));
    if (b != 4'd0)
      chk("reconstruct", 32'(int'(quotient) * int'(b) + int'(remainder)), 32'(a));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_quotient"}, 32'(quotient), 32'd0);
    chk({tag, "_remainder"}, 32'(remainder), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
  endtask

  initial begin
    int k;
    int nd;
    start = 1'b0; dividend = 8'd0; divisor = 4'd0;
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(8'd200, 4'd7, 28, 4, 0);
    // Asynchronous reset mid-cycle clears outputs before the next edge.
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run(8'd200, 4'd7, 28, 4, 0);

    run(8'd255, 4'd1, 255, 0, 0);
    run(8'd5, 4'd9, 0, 5, 0);
    run(8'd0, 4'd15, 0, 0, 0);
    run(8'd255, 4'd15, 17, 0, 0);
    run(8'd77, 4'd0, 255, 0, 1);
    run(8'd77, 4'd5, 15, 2, 0);

    // Start during busy and input changes are ignored.
    @(posedge clk); #1;
    start = 1'b1; dividend = 8'd100; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; dividend = 8'd7; divisor = 4'd2;
    @(posedge clk); #1;
    start = 1'b0; dividend = 8'd255; divisor = 4'd0;
    k = 4;
    while (!done && k < 20) begin @(posedge clk); #1; k++; end
    chk("hs_latency", 32'(k), 32'd8);
    chk("hs_quotient", 32'(quotient), 32'd33);
    chk("hs_remainder", 32'(remainder), 32'd1);
    chk("hs_dbz", 32'(div_by_zero), 32'd0);

    // Back-to-back with start held: done pulses 9 cycles apart.
    @(posedge clk); #1;
    start = 1'b1; dividend = 8'd60; divisor = 4'd7;
    k = 0;
    while (!done && k < 20) begin @(posedge clk); #1; k++; end
    chk("b2b_first_q", 32'(quotient), 32'd8);
    chk("b2b_first_r", 32'(remainder), 32'd4);
    dividend = 8'd90; divisor = 4'd4;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!done && k < 20);
    chk("b2b_spacing", 32'(k), 32'd9);
    chk("b2b_second_q", 32'(quotient), 32'd22);
    chk("b2b_second_r", 32'(remainder), 32'd2);
    start = 1'b0;
    @(posedge clk); #1;

    // Reset mid-operation aborts with no done pulse.
    start = 1'b1; dividend = 8'd100; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); end
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    nd = 0;
    repeat (10) begin @(posedge clk); #1; if (done) nd++; end
    chk("mid_reset_no_done", 32'(nd), 32'd0);
    run(8'd150, 4'd11, 13, 7, 0);

    for (int a = 0; a < 256; a++)
      for (int b = 1; b < 16; b++)
        run(8'(a), 4'(b), a / b, a % b, 0);

    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
